// File: rtl/tb_run_sequencer_if.sv
// Core observation bundle watched by the run sequencer: tohost write strobe,
// commit pulse and fetch handshake. The core side drives it (master), the
// sequencer only observes it (slave).
interface tb_run_sequencer_if;
  logic        tohost_vld;
  logic [31:0] tohost_data;
  logic        cmt_vld;
  logic        ifu_hsk;

  modport master (
    output tohost_vld,
    output tohost_data,
    output cmt_vld,
    output ifu_hsk
  );

  modport slave (
    input tohost_vld,
    input tohost_data,
    input cmt_vld,
    input ifu_hsk
  );
endinterface

// File: rtl/tb_run_sequencer.sv
// Run controller for one self-checking program run on the N100 core.
// Holds the core in reset, releases it, supervises execution (tohost result,
// hang and timeout detection), drains, then reports a frozen result and
// cycle/fetch/commit counts until the next start.
module tb_run_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter int unsigned HANG_CYCLES     = 4096,
  parameter int unsigned DRAIN_CYCLES    = 8
) (
  input  logic                 tb_clk,
  input  logic                 tb_rst_n,
  input  logic                 start,
  output logic                 core_rst_n,
  tb_run_sequencer_if.slave    core,
  output logic                 run_busy,
  output logic                 run_done,
  output logic                 run_pass,
  output logic                 run_fail,
  output logic [1:0]           fail_code,
  output logic [30:0]          fail_testnum,
  output logic [31:0]          run_cycles,
  output logic [31:0]          ifu_cnt,
  output logic [31:0]          cmt_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_RST_HOLD = 3'd1;
  localparam logic [2:0] ST_RUN      = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

  localparam logic [15:0] HOLD_LAST  = 16'(RST_HOLD_CYCLES - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(DRAIN_CYCLES - 1);
  localparam logic [31:0] HANG_LAST  = 32'(HANG_CYCLES - 1);
  localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  st;
  logic [2:0]  st_nxt;
  logic [15:0] phase_cnt;
  logic [31:0] idle_cnt;
  logic        res_pass;
  logic        res_fail;
  logic        start_acc;
  logic        in_run;
  logic        tohost_evt;
  logic        hang_evt;
  logic        tmo_evt;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  // Event decode and next-state selection
  always_comb begin
    start_acc  = start && ((st == ST_IDLE) || (st == ST_DONE));
    in_run     = (st == ST_RUN);
    tohost_evt = core.tohost_vld && (core.tohost_data != '0);
    hang_evt   = !core.cmt_vld && (idle_cnt == HANG_LAST);
    tmo_evt    = (run_cycles == TMO_LAST);
    st_nxt     = st;
    case (st)
      ST_IDLE, ST_DONE: if (start) st_nxt = ST_RST_HOLD;
      ST_RST_HOLD:      if (phase_cnt == HOLD_LAST) st_nxt = ST_RUN;
      ST_RUN:           if (tohost_evt || hang_evt || tmo_evt) st_nxt = ST_DRAIN;
      ST_DRAIN:         if (phase_cnt == DRAIN_LAST) st_nxt = ST_DONE;
      default:          st_nxt = ST_IDLE;
    endcase
  end

  // State register and status outputs, registered from the next state so
  // every output changes on the same edge as the state itself
  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      st         <= ST_IDLE;
      core_rst_n <= 1'b0;
      run_busy   <= 1'b0;
      run_done   <= 1'b0;
      run_pass   <= 1'b0;
      run_fail   <= 1'b0;
    end else begin
      st         <= st_nxt;
      core_rst_n <= (st_nxt == ST_RUN) || (st_nxt == ST_DRAIN);
      run_busy   <= (st_nxt == ST_RST_HOLD) || (st_nxt == ST_RUN) || (st_nxt == ST_DRAIN);
      run_done   <= (st_nxt == ST_DONE);
      run_pass   <= (st_nxt == ST_DONE) && res_pass;
      run_fail   <= (st_nxt == ST_DONE) && res_fail;
    end
  end

  // Dwell counter for RST_HOLD and DRAIN, restarted on every state change
  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      phase_cnt <= '0;
    end else if (st_nxt != st) begin
      phase_cnt <= '0;
    end else if ((st == ST_RST_HOLD) || (st == ST_DRAIN)) begin
      phase_cnt <= phase_cnt + 16'd1;
    end
  end

  // Run statistics: counted only in RUN, so they freeze from DRAIN onward
  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      run_cycles <= '0;
      ifu_cnt    <= '0;
      cmt_cnt    <= '0;
      idle_cnt   <= '0;
    end else if (start_acc) begin
      run_cycles <= '0;
      ifu_cnt    <= '0;
      cmt_cnt    <= '0;
      idle_cnt   <= '0;
    end else if (in_run) begin
      run_cycles <= sat_inc(run_cycles);
      if (core.ifu_hsk) ifu_cnt <= sat_inc(ifu_cnt);
      if (core.cmt_vld) begin
        cmt_cnt  <= sat_inc(cmt_cnt);
        idle_cnt <= '0;
      end else begin
        idle_cnt <= sat_inc(idle_cnt);
      end
    end
  end

  // Result capture on the terminating RUN cycle; tohost beats hang beats timeout
  always_ff @(posedge tb_clk or negedge tb_rst_n) begin
    if (!tb_rst_n) begin
      res_pass     <= 1'b0;
      res_fail     <= 1'b0;
      fail_code    <= 2'd0;
      fail_testnum <= '0;
    end else if (start_acc) begin
      res_pass     <= 1'b0;
      res_fail     <= 1'b0;
      fail_code    <= 2'd0;
      fail_testnum <= '0;
    end else if (in_run) begin
      if (tohost_evt) begin
        if (core.tohost_data == 32'd1) begin
          res_pass <= 1'b1;
        end else begin
          res_fail     <= 1'b1;
          fail_code    <= 2'd1;
          fail_testnum <= core.tohost_data[31:1];
        end
      end else if (hang_evt) begin
        res_fail  <= 1'b1;
        fail_code <= 2'd3;
      end else if (tmo_evt) begin
        res_fail  <= 1'b1;
        fail_code <= 2'd2;
      end
    end
  end

endmodule

// File: tb/tb_tb_run_sequencer.sv
// Scoreboard bench for tb_run_sequencer: each run pushes its hand-computed
// result, a monitor pops and compares on every rising run_done.
module tb_tb_run_sequencer;

  localparam int unsigned K_PASS   = 0;
  localparam int unsigned K_TFAIL  = 1;
  localparam int unsigned K_HANG   = 2;
  localparam int unsigned K_TMO    = 3;
  localparam int unsigned K_PRIO   = 4;
  localparam int unsigned K_RSTMID = 5;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [1:0]  code;
    logic [30:0] tn;
    logic [31:0] cyc;
    logic [31:0] cmt;
    logic [31:0] ifu;
  } exp_t;

  exp_t sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  logic        tb_clk   = 1'b0;
  logic        tb_rst_n = 1'b0;
  logic        start    = 1'b0;
  logic        core_rst_n;
  logic        run_busy, run_done, run_pass, run_fail;
  logic [1:0]  fail_code;
  logic [30:0] fail_testnum;
  logic [31:0] run_cycles, ifu_cnt, cmt_cnt;

  tb_run_sequencer_if core_if();

  tb_run_sequencer #(
    .RST_HOLD_CYCLES(4),
    .TIMEOUT_CYCLES (100),
    .HANG_CYCLES    (16),
    .DRAIN_CYCLES   (2)
  ) dut (
    .tb_clk       (tb_clk),
    .tb_rst_n     (tb_rst_n),
    .start        (start),
    .core_rst_n   (core_rst_n),
    .core         (core_if),
    .run_busy     (run_busy),
    .run_done     (run_done),
    .run_pass     (run_pass),
    .run_fail     (run_fail),
    .fail_code    (fail_code),
    .fail_testnum (fail_testnum),
    .run_cycles   (run_cycles),
    .ifu_cnt      (ifu_cnt),
    .cmt_cnt      (cmt_cnt)
  );

  always #5 tb_clk = ~tb_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk_exp(input logic p, input logic f, input logic [1:0] c,
                                  input logic [30:0] tn, input logic [31:0] cyc,
                                  input logic [31:0] cmt, input logic [31:0] ifu);
    exp_t e;
    e.pass = p; e.fail = f; e.code = c; e.tn = tn;
    e.cyc = cyc; e.cmt = cmt; e.ifu = ifu;
    return e;
  endfunction

  task automatic idle_inputs();
    start                = 1'b0;
    core_if.tohost_vld   = 1'b0;
    core_if.tohost_data  = '0;
    core_if.cmt_vld      = 1'b0;
    core_if.ifu_hsk      = 1'b0;
  endtask

  // Input vector for RUN cycle k (k counts from 1 and runs on into DRAIN)
  task automatic drive(input int unsigned kind, input int unsigned k);
    logic [31:0] kb;
    kb = k;
    idle_inputs();
    case (kind)
      K_PASS: begin
        core_if.cmt_vld = 1'b1;
        core_if.ifu_hsk = kb[0];
        if (k == 50) begin core_if.tohost_vld = 1'b1; core_if.tohost_data = 32'd1; end
        if (k == 30 || k == 51) start = 1'b1;
      end
      K_TFAIL: begin
        core_if.cmt_vld = 1'b1;
        core_if.ifu_hsk = 1'b1;
        if (k == 10) begin core_if.tohost_vld = 1'b1; core_if.tohost_data = 32'd0; end
        if (k == 20) begin core_if.tohost_vld = 1'b1; core_if.tohost_data = 32'h0000_000B; end
        if (k == 21 || k == 22) begin core_if.tohost_vld = 1'b1; core_if.tohost_data = 32'd1; end
      end
      K_HANG, K_RSTMID: begin
        core_if.cmt_vld = (k <= 10);
        core_if.ifu_hsk = 1'b1;
      end
      K_TMO: begin
        core_if.cmt_vld = kb[0];
        core_if.ifu_hsk = 1'b0;
      end
      K_PRIO: begin
        core_if.cmt_vld = kb[0];
        core_if.ifu_hsk = 1'b1;
        if (k == 100) begin core_if.tohost_vld = 1'b1; core_if.tohost_data = 32'd1; end
      end
      default: ;
    endcase
  endtask

  task automatic do_run(input int unsigned kind, input exp_t e, input bit push);
    int unsigned lo;
    int unsigned k;
    bit seen;
    if (push) sb.push_back(e);
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    chk("start_busy",   run_busy,   1);
    chk("start_done",   run_done,   0);
    chk("start_cycles", run_cycles, 0);
    chk("start_cmt",    cmt_cnt,    0);
    chk("start_code",   fail_code,  0);
    lo = 0;
    while (!core_rst_n && lo < 20) begin
      lo++;
      @(negedge tb_clk);
    end
    chk("hold_len", lo, 4);
    k = 1;
    seen = 0;
    while (k < 300 && !seen) begin
      if (run_done) begin
        seen = 1;
      end else begin
        if (kind == K_RSTMID && k == 15) begin
          tb_rst_n = 1'b0;
          #1;
          chk("arst_core_rst_n", core_rst_n, 0);
          chk("arst_busy",       run_busy,   0);
          chk("arst_cycles",     run_cycles, 0);
          chk("arst_ifu",        ifu_cnt,    0);
          chk("arst_cmt",        cmt_cnt,    0);
          idle_inputs();
          @(negedge tb_clk);
          tb_rst_n = 1'b1;
          @(negedge tb_clk);
          @(negedge tb_clk);
          chk("arst_idle_busy", run_busy,   0);
          chk("arst_idle_done", run_done,   0);
          chk("arst_idle_core", core_rst_n, 0);
          return;
        end
        drive(kind, k);
        @(negedge tb_clk);
        k++;
      end
    end
    idle_inputs();
    chk("done_seen", run_done, 1);
    chk("done_latency", k, e.cyc + 3);
    chk("done_core_rst_n", core_rst_n, 0);
    repeat (3) @(negedge tb_clk);
    chk("done_hold", run_done, 1);
  endtask

  // Monitor: compare the result presented on each rising run_done
  initial begin : monitor
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge tb_clk);
      if (run_done && !prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", run_done, 0);
        end else begin
          e = sb.pop_front();
          chk("run_pass",     run_pass,     e.pass);
          chk("run_fail",     run_fail,     e.fail);
          chk("fail_code",    fail_code,    e.code);
          chk("fail_testnum", fail_testnum, e.tn);
          chk("run_cycles",   run_cycles,   e.cyc);
          chk("cmt_cnt",      cmt_cnt,      e.cmt);
          chk("ifu_cnt",      ifu_cnt,      e.ifu);
        end
      end
      prev = run_done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    idle_inputs();
    tb_rst_n = 1'b0;
    repeat (2) @(negedge tb_clk);
    chk("rst_core_rst_n", core_rst_n,   0);
    chk("rst_busy",       run_busy,     0);
    chk("rst_done",       run_done,     0);
    chk("rst_pass",       run_pass,     0);
    chk("rst_fail",       run_fail,     0);
    chk("rst_code",       fail_code,    0);
    chk("rst_testnum",    fail_testnum, 0);
    chk("rst_cycles",     run_cycles,   0);
    chk("rst_ifu",        ifu_cnt,      0);
    chk("rst_cmt",        cmt_cnt,      0);
    tb_rst_n = 1'b1;
    repeat (2) @(negedge tb_clk);

    do_run(K_PASS,   mk_exp(1'b1, 1'b0, 2'd0, 31'd0, 32'd50,  32'd50, 32'd25),  1'b1);
    do_run(K_TFAIL,  mk_exp(1'b0, 1'b1, 2'd1, 31'd5, 32'd20,  32'd20, 32'd20),  1'b1);
    do_run(K_HANG,   mk_exp(1'b0, 1'b1, 2'd3, 31'd0, 32'd26,  32'd10, 32'd26),  1'b1);
    do_run(K_TMO,    mk_exp(1'b0, 1'b1, 2'd2, 31'd0, 32'd100, 32'd50, 32'd0),   1'b1);
    do_run(K_PRIO,   mk_exp(1'b1, 1'b0, 2'd0, 31'd0, 32'd100, 32'd50, 32'd100), 1'b1);
    do_run(K_RSTMID, mk_exp(1'b0, 1'b0, 2'd0, 31'd0, 32'd0,   32'd0,  32'd0),   1'b0);
    do_run(K_PASS,   mk_exp(1'b1, 1'b0, 2'd0, 31'd0, 32'd50,  32'd50, 32'd25),  1'b1);

    repeat (4) @(negedge tb_clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
